iob_fifo_wptr_ctrl: RTL and testbench
=====================================

// Module: iob_fifo_wptr_ctrl
// PURPOSE
//  Write-side pointer controller of the async FIFO.
//  - Keeps the write pointer in binary and Gray form.
//  - Synchronises the read-domain Gray pointer into this clock domain and converts it to binary.
//  - Produces registered full flag, fill level and write address for the FIFO RAM.
//  - Its w_gray_o feeds the read-side synchroniser.
// PARAMETERS
//  ADDR_W       4  RAM address width; depth = 2**ADDR_W; pointer width PTR_W = ADDR_W+1; ADDR_W>=1
//  SYNC_STAGES  2  flops in the r_gray_i synchroniser chain; SYNC_STAGES>=2
// PORTS
//  clk_i        in   1       write-domain clock
//  arst_n_i     in   1       asynchronous reset, active-low
//  cke_i        in   1       clock enable; low = every register holds
//  w_en_i       in   1       write request
//  r_gray_i     in   PTR_W   read pointer, Gray coded, asynchronous to clk_i
//  w_addr_o     out  ADDR_W  RAM write address for the current cycle
//  w_ack_o      out  1       write accepted this cycle (combinational)
//  w_full_o     out  1       FIFO full (registered)
//  w_level_o    out  PTR_W   entries in FIFO as seen from write side (registered)
//  w_gray_o     out  PTR_W   write pointer, Gray coded (registered, glitch-free)
//  w_ovf_o      out  1       sticky overflow: write attempted while full
// BEHAVIOUR
//  Reset (arst_n_i=0, immediate): all registers 0. Outputs: w_full_o=0, w_level_o=0, w_gray_o=0,
//   w_addr_o=0, w_ovf_o=0. Synchroniser flops are also 0.
//  Clock enable: all updates below happen only on rising clk_i with cke_i=1.
//  Accept: w_ack_o = w_en_i & ~w_full_o & cke_i. A write while full is dropped, sets w_ovf_o, and
//   leaves the pointers unchanged. w_ovf_o clears only on reset.
//  Pointer update: bin_next = w_ack_o ? w_bin+1 : w_bin, modulo 2**PTR_W.
//   gray_next = bin_next ^ (bin_next>>1). w_bin <= bin_next; w_gray_o <= gray_next.
//  Address: w_addr_o = w_bin[ADDR_W-1:0]. The data for an accepted write goes to the address
//   presented in that same cycle.
//  Synchroniser: r_gray_i passes through SYNC_STAGES flops to give r_gray_s.
//   r_bin_s = Gray-to-binary of r_gray_s (combinational sub-module).
//  Full: w_full_o <= (gray_next == {~r_gray_s[PTR_W-1:PTR_W-2], r_gray_s[PTR_W-3:0]}).
//   For ADDR_W=1 the low slice is empty.
//   A write that fills the FIFO asserts w_full_o on the next cycle, so a back-to-back write is refused.
//  Level: w_level_o <= (bin_next - r_bin_s), modulo 2**PTR_W. Range 0..2**ADDR_W.
//  Latency: a change on r_gray_i reaches w_full_o and w_level_o after SYNC_STAGES+1 rising edges.
//   Full is therefore pessimistic (never falsely clear).
//  Wrap-around: the pointer wraps after 2**PTR_W writes. The MSB distinguishes full from empty.
//   Gray changes exactly one bit per accepted write.
//  Simultaneous events:
//   - Write plus read-pointer advance in the same cycle: full and level use gray_next/bin_next and
//     the already-synchronised r value.
//   - The new r value takes effect after the synchroniser latency.
//  Reset mid-operation: pointers return to 0 asynchronously. The read side must be reset together
//   with this block (system rule; not checked here).
// STRUCTURE
//  Shared FIFO header (iob_fifo_ptr_defs.vh): PTR_W = ADDR_W+1, DEPTH = 1<<ADDR_W,
//   bin-to-Gray function. Also used by the read-side controller.
//  Sub-module: iob_gray2bin #(.DATA_W(PTR_W)) converts r_gray_s to r_bin_s.
//  Everything else is local: sync chain, binary/Gray pointer regs, full/level/ovf regs.
// TESTING (ADDR_W=2, SYNC_STAGES=2, depth 4, PTR_W=3)
//  1. Reset, then r_gray_i=000 and 4 consecutive writes:
//     -> w_gray_o steps 001, 011, 010, 110; w_addr_o steps 0, 1, 2, 3.
//     -> After the 4th write, w_full_o=1 and w_level_o=4.
//  2. While full, w_en_i=1 for 2 cycles:
//     -> w_ack_o=0; w_gray_o stays 110; w_ovf_o=1 and stays 1 until reset.
//  3. While full, set r_gray_i=001 (one read):
//     -> w_full_o=0 and w_level_o=3 exactly 3 edges later; the next write is accepted at w_addr_o=0.
//  4. 8 writes, each matched by r_gray_i tracking the written pointer:
//     -> w_gray_o returns to 000 and w_addr_o wraps 3->0.
//     -> w_full_o is never 1; w_level_o never exceeds 2 (synchroniser lag).
//  5. cke_i=0 with w_en_i=1 and r_gray_i changing for 5 cycles:
//     -> w_ack_o=0; w_gray_o, w_level_o, w_full_o and the sync chain are unchanged.
//  6. Drive arst_n_i low between clock edges at level 3:
//     -> all outputs are 0 before the next edge; normal writes resume after release.

Source files
------------

// File: rtl/iob_fifo_wptr_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO controllers (write and read side).
// Pointer width is ADDR_W+1; the extra MSB separates full from empty.
package iob_fifo_wptr_ctrl_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/iob_fifo_wptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module iob_gray2bin #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] gray,
    output logic [DATA_W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/iob_fifo_wptr_ctrl.sv
// Write-side pointer controller of the async FIFO: binary/Gray write pointer,
// read-pointer synchroniser, registered full flag, fill level and sticky overflow.
module iob_fifo_wptr_ctrl
    import iob_fifo_wptr_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              w_en_i,
    input  logic [ADDR_W:0]   r_gray_i,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              w_ack_o,
    output logic              w_full_o,
    output logic [ADDR_W:0]   w_level_o,
    output logic [ADDR_W:0]   w_gray_o,
    output logic              w_ovf_o
);

    localparam int PTR_W = ptr_width(ADDR_W);
    // Full when the write pointer equals the read pointer with its two Gray MSBs inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] w_bin;
    logic [PTR_W-1:0] bin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] r_gray_s;
    logic [PTR_W-1:0] r_bin_s;

    assign w_ack_o   = w_en_i & ~w_full_o & cke_i;
    assign bin_next  = w_bin + PTR_W'(w_ack_o);
    assign gray_next = PTR_W'(bin2gray(MAX_PTR_W'(bin_next)));
    assign w_addr_o  = w_bin[ADDR_W-1:0];
    assign r_gray_s  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else if (cke_i) begin
            sync_q[0] <= r_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    iob_gray2bin #(
        .DATA_W(PTR_W)
    ) u_gray2bin (
        .gray(r_gray_s),
        .bin (r_bin_s)
    );

    // Full and level look ahead to bin_next/gray_next so a filling write blocks the next one.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            w_bin     <= '0;
            w_gray_o  <= '0;
            w_full_o  <= 1'b0;
            w_level_o <= '0;
            w_ovf_o   <= 1'b0;
        end else if (cke_i) begin
            w_bin     <= bin_next;
            w_gray_o  <= gray_next;
            w_full_o  <= (gray_next == (r_gray_s ^ FULL_MASK));
            w_level_o <= bin_next - r_bin_s;
            if (w_en_i && w_full_o) begin
                w_ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo_wptr_ctrl.sv
// Bench for iob_fifo_wptr_ctrl (ADDR_W=2): directed scenarios plus a random run,
// checked against a pointer-count model of the FIFO write side.
module tb_iob_fifo_wptr_ctrl;

    localparam int ADDR_W = 2;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 4;
    localparam int PMOD   = 8;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       cke;
    logic       w_en;
    logic [2:0] r_gray;
    logic [1:0] w_addr;
    logic       w_ack;
    logic       w_full;
    logic [2:0] w_level;
    logic [2:0] w_gray;
    logic       w_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: counts of written/read entries modulo 2*DEPTH; synchroniser as a delay line of read counts.
    int m_wbin, m_full, m_level, m_ovf, r_ptr;
    int m_hist [SYNC];

    iob_fifo_wptr_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .w_en_i(w_en), .r_gray_i(r_gray),
        .w_addr_o(w_addr), .w_ack_o(w_ack), .w_full_o(w_full), .w_level_o(w_level),
        .w_gray_o(w_gray), .w_ovf_o(w_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] v;
        v = 3'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int exp_ack();
        return (w_en && cke && m_full == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_wbin = 0; m_full = 0; m_level = 0; m_ovf = 0; r_ptr = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    endtask

    task automatic set_inputs(input logic en, input logic ck, input int rp);
        w_en = en; cke = ck; r_ptr = rp; r_gray = to_gray(rp);
    endtask

    // Advance one clock: model updates at the rising edge, return at the falling edge.
    task automatic cycle();
        int ack, wn, diff;
        @(posedge clk);
        if (cke) begin
            ack = (w_en && m_full == 0) ? 1 : 0;
            if (w_en && m_full != 0) m_ovf = 1;
            wn = (m_wbin + ack) % PMOD;
            diff = (wn - m_hist[SYNC-1] + PMOD) % PMOD;
            m_full = (diff == DEPTH) ? 1 : 0;
            m_level = diff;
            m_wbin = wn;
            for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = r_ptr;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_inputs(1'b0, 1'b1, 0);
        arst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({w_full, w_level, w_gray, w_addr, w_ovf} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got full=%0b level=%0d gray=%0d addr=%0d ovf=%0b required all 0",
                     w_full, w_level, w_gray, w_addr, w_ovf);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [2:0] gtab [4];
        gtab[0] = 3'b001; gtab[1] = 3'b011; gtab[2] = 3'b010; gtab[3] = 3'b110;
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b1, 1'b1, 0);
            #1;
            n_checks++;
            if (w_ack !== 1'b1 || w_addr !== 2'(i)) begin
                n_fail++;
                $display("FAIL fill_ack_addr[%0d] got ack=%0b addr=%0d required ack=1 addr=%0d", i, w_ack, w_addr, i);
            end
            cycle();
            n_checks++;
            if (w_gray !== gtab[i]) begin
                n_fail++;
                $display("FAIL fill_gray[%0d] got %b required %b", i, w_gray, gtab[i]);
            end
        end
        n_checks++;
        if (w_full !== 1'b1 || w_level !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_full got full=%0b level=%0d required full=1 level=4", w_full, w_level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            set_inputs(1'b1, 1'b1, 0);
            #1;
            n_checks++;
            if (w_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_ack[%0d] got %0b required 0", i, w_ack);
            end
            cycle();
            n_checks++;
            if (w_gray !== 3'b110 || w_ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_state[%0d] got gray=%b ovf=%0b required gray=110 ovf=1", i, w_gray, w_ovf);
            end
        end
        set_inputs(1'b0, 1'b1, 0);
        cycle();
        cycle();
        n_checks++;
        if (w_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got %0b required 1", w_ovf);
        end
    endtask

    task automatic test_read_latency();
        set_inputs(1'b0, 1'b1, 1);
        for (int e = 1; e <= 3; e++) begin
            cycle();
            n_checks++;
            if (w_full !== ((e < 3) ? 1'b1 : 1'b0) || w_level !== ((e < 3) ? 3'd4 : 3'd3)) begin
                n_fail++;
                $display("FAIL read_latency_edge%0d got full=%0b level=%0d required full=%0b level=%0d",
                         e, w_full, w_level, (e < 3), (e < 3) ? 4 : 3);
            end
        end
        set_inputs(1'b1, 1'b1, 1);
        #1;
        n_checks++;
        if (w_ack !== 1'b1 || w_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL read_next_write got ack=%0b addr=%0d required ack=1 addr=0", w_ack, w_addr);
        end
        cycle();
        n_checks++;
        if (w_gray !== to_gray(m_wbin) || w_level !== 3'(m_level) || w_full !== 1'(m_full)) begin
            n_fail++;
            $display("FAIL read_after_write got gray=%b level=%0d full=%0b required gray=%b level=%0d full=%0d",
                     w_gray, w_level, w_full, to_gray(m_wbin), m_level, m_full);
        end
    endtask

    task automatic test_wrap();
        int max_level = 0;
        for (int k = 0; k < 8; k++) begin
            set_inputs(1'b1, 1'b1, (k + 1) % PMOD);
            #1;
            n_checks++;
            if (w_ack !== 1'b1 || w_addr !== 2'(k % DEPTH)) begin
                n_fail++;
                $display("FAIL wrap_ack_addr[%0d] got ack=%0b addr=%0d required ack=1 addr=%0d", k, w_ack, w_addr, k % DEPTH);
            end
            cycle();
            if (int'(w_level) > max_level) max_level = int'(w_level);
            n_checks++;
            if (w_full !== 1'b0 || w_level !== 3'(m_level) || w_gray !== to_gray(m_wbin)) begin
                n_fail++;
                $display("FAIL wrap_state[%0d] got full=%0b level=%0d gray=%b required full=0 level=%0d gray=%b",
                         k, w_full, w_level, w_gray, m_level, to_gray(m_wbin));
            end
        end
        n_checks++;
        if (w_gray !== 3'b000 || w_addr !== 2'd0 || max_level > 2) begin
            n_fail++;
            $display("FAIL wrap_end got gray=%b addr=%0d max_level=%0d required gray=000 addr=0 max_level<=2",
                     w_gray, w_addr, max_level);
        end
    endtask

    task automatic test_cke_hold();
        int keep_r;
        logic [2:0] g0, l0;
        logic f0;
        keep_r = r_ptr;
        g0 = w_gray; l0 = w_level; f0 = w_full;
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'b1, 1'b0, 0);
            r_gray = 3'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (w_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL cke_ack[%0d] got %0b required 0", i, w_ack);
            end
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (w_gray !== g0 || w_level !== l0 || w_full !== f0) begin
                n_fail++;
                $display("FAIL cke_hold[%0d] got gray=%b level=%0d full=%0b required gray=%b level=%0d full=%0b",
                         i, w_gray, w_level, w_full, g0, l0, f0);
            end
        end
        // Sync chain contents show up in level over the next edges; writes pending so level moves.
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b1, 1'b1, keep_r);
            cycle();
            n_checks++;
            if (w_level !== 3'(m_level) || w_full !== 1'(m_full) || w_gray !== to_gray(m_wbin)) begin
                n_fail++;
                $display("FAIL cke_resume[%0d] got level=%0d full=%0b gray=%b required level=%0d full=%0d gray=%b",
                         i, w_level, w_full, w_gray, m_level, m_full, to_gray(m_wbin));
            end
        end
    endtask

    task automatic test_async_reset();
        test_reset();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 1'b1, 0);
            cycle();
        end
        set_inputs(1'b0, 1'b1, 0);
        n_checks++;
        if (w_level !== 3'd3) begin
            n_fail++;
            $display("FAIL areset_pre_level got %0d required 3", w_level);
        end
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({w_full, w_level, w_gray, w_addr, w_ovf} !== 10'd0) begin
            n_fail++;
            $display("FAIL areset_outputs got full=%0b level=%0d gray=%0d addr=%0d ovf=%0b required all 0",
                     w_full, w_level, w_gray, w_addr, w_ovf);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_inputs(1'b1, 1'b1, 0);
            #1;
            n_checks++;
            if (w_ack !== 1'b1 || w_addr !== 2'(i)) begin
                n_fail++;
                $display("FAIL areset_resume[%0d] got ack=%0b addr=%0d required ack=1 addr=%0d", i, w_ack, w_addr, i);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        int rp;
        test_reset();
        for (int c = 0; c < 300; c++) begin
            rp = r_ptr;
            if (rp != m_wbin && $urandom_range(0, 2) == 0) rp = (rp + 1) % PMOD;
            set_inputs(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), rp);
            #1;
            n_checks++;
            if (w_ack !== 1'(exp_ack()) || w_addr !== 2'(m_wbin % DEPTH)) begin
                n_fail++;
                $display("FAIL rand_comb[%0d] got ack=%0b addr=%0d required ack=%0d addr=%0d",
                         c, w_ack, w_addr, exp_ack(), m_wbin % DEPTH);
            end
            cycle();
            n_checks++;
            if (w_gray !== to_gray(m_wbin) || w_full !== 1'(m_full) || w_level !== 3'(m_level) || w_ovf !== 1'(m_ovf)) begin
                n_fail++;
                $display("FAIL rand_reg[%0d] got gray=%b full=%0b level=%0d ovf=%0b required gray=%b full=%0d level=%0d ovf=%0d",
                         c, w_gray, w_full, w_level, w_ovf, to_gray(m_wbin), m_full, m_level, m_ovf);
            end
        end
    endtask

    initial begin
        arst_n = 1'b0;
        cke = 1'b1;
        w_en = 1'b0;
        r_gray = 3'd0;
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_read_latency();
        test_reset();
        test_wrap();
        test_cke_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
